ets_measure_ctrl: RTL and testbench
===================================

// Module: ets_measure_ctrl
// PURPOSE
//  Sequencer between RISC-V core issue/retire strobes and the ETS cycle_counter. Converts each monitored
//  instruction into start/active/done pulses, enforces a timeout watchdog, and captures {opcode,cycles,timeout}
//  records into a small FIFO drained by the signature checker via valid/ready. One measurement in flight.
// PARAMETERS
//  FIFO_DEPTH      4      record FIFO entries; power of 2, >=2
//  TIMEOUT_CYCLES  1024   MEASURE cycles before a forced done; 2..2^31-1
//  OPC_W           7      opcode tag width
// PORTS
//  clk             in   1      single clock, rising edge
//  rst_n           in   1      asynchronous active-low reset
//  enable          in   1      monitoring enable; low aborts any measurement
//  core_issue      in   1      pulse: monitored instruction issued
//  core_opcode     in   OPC_W  opcode, sampled with core_issue
//  core_retire     in   1      pulse: in-flight instruction retired
//  ctr_start       out  1      to cycle_counter instr_start
//  ctr_active      out  1      to cycle_counter instr_active
//  ctr_done        out  1      to cycle_counter instr_done
//  ctr_count       in   32     from cycle_counter cycle_count
//  ctr_valid       in   1      from cycle_counter count_valid
//  sig_valid       out  1      FIFO head valid
//  sig_ready       in   1      consumer ready
//  sig_opcode      out  OPC_W  head opcode
//  sig_cycles      out  32     head cycle count
//  sig_timeout     out  1      head was timeout-terminated
//  busy            out  1      state != IDLE
//  drop_count      out  16     saturating count of dropped issues/records
//  overflow        out  1      sticky: record lost to full FIFO
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; FIFO empty; watchdog 0; drop_count 0; overflow 0.
//  All ctr_* outputs registered. States IDLE, MEASURE, LATCH.
//  IDLE: core_issue&enable at edge N -> latch opcode; ctr_start=1 for cycle N+1 only; ctr_active=1 from N+1;
//   enter MEASURE; watchdog cleared.
//  MEASURE: watchdog +1 per cycle. core_retire -> ctr_done=1 next cycle (single pulse), ctr_active=0, timeout=0,
//   go LATCH. Watchdog reaching TIMEOUT_CYCLES-1 without retire -> same exit with timeout=1.
//   Retire on the timeout cycle: retire wins, timeout=0.
//  LATCH: ctr_done low; wait for ctr_valid (arrives the cycle after ctr_done); capture ctr_count.
//   FIFO not full -> push {opcode,ctr_count,timeout}; full -> discard, drop_count+1, overflow=1.
//   Return IDLE same edge. Earliest next ctr_start: 4 cycles after previous ctr_start.
//  core_issue while state != IDLE (including issue coincident with retire): ignored, drop_count+1.
//  core_retire in IDLE or LATCH: ignored, no count change.
//  enable low in MEASURE: ctr_active=0 next cycle, no ctr_done, no record, return IDLE.
//   enable low in LATCH: capture still completes. enable gates only new issues.
//  drop_count saturates at 16'hFFFF. Drop and discard in one cycle count once each (+2, saturating).
//  FIFO: first-word-fall-through; head on sig_* while sig_valid; pop on sig_valid&sig_ready.
//   Push+pop same cycle when full is legal: count unchanged, no drop.
//   Head fields hold while sig_valid & !sig_ready. Pointers wrap mod FIFO_DEPTH.
//  Async reset mid-operation returns to reset state immediately; in-flight measurement and FIFO contents lost.
// STRUCTURE
//  ets_pkg: state enum (IDLE/MEASURE/LATCH), record width localparam (OPC_W+33), record field offsets.
//  Sub-module ets_sig_fifo: parameterised FWFT FIFO (width, depth) with full/empty, no overflow write.
//  Top: FSM, watchdog, drop/overflow logic.
// TESTING
//  1 issue op=0x33, retire 5 cycles after ctr_start -> ctr_start 1 cycle, ctr_done 1 cycle;
//    record {0x33, cycles=6, timeout=0}.
//  2 TIMEOUT_CYCLES=16, issue, no retire -> forced ctr_done after 16 MEASURE cycles; record timeout=1;
//    retire on 16th cycle -> timeout=0.
//  3 sig_ready=0, 5 measurements, FIFO_DEPTH=4 -> 4 records kept in order, 5th dropped,
//    drop_count=1, overflow=1.
//  4 issue during MEASURE and coincident with retire -> no extra ctr_start, drop_count=2, one record only.
//  5 enable low 3 cycles into MEASURE -> ctr_active falls, no ctr_done, no record, busy=0 next cycle.
//  6 rst_n low mid-MEASURE with 2 FIFO entries -> all outputs 0 asynchronously; FIFO empty after release.

Source files
------------

// File: rtl/ets_pkg.sv
// Shared types and record layout for the ETS measurement sequencer.
// Record layout (LSB first): timeout flag, 32-bit cycle count, opcode tag.
package ets_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LATCH   = 2'd2
  } ets_state_e;

  localparam int unsigned CYC_W       = 32;
  localparam int unsigned OPC_W_DEF   = 7;
  localparam int unsigned REC_W_DEF   = OPC_W_DEF + 33;

  localparam int unsigned REC_TO_BIT  = 0;
  localparam int unsigned REC_CYC_LSB = 1;
  localparam int unsigned REC_OPC_LSB = REC_CYC_LSB + CYC_W;

  function automatic int unsigned rec_width(input int unsigned opc_w);
    return opc_w + CYC_W + 1;
  endfunction

endpackage

// File: rtl/ets_sig_fifo.sv
// First-word-fall-through FIFO holding measurement records.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   wr_en, wr_data  write request; ignored when full unless a read happens the same cycle
//   rd_en           pop the head (only effective when not empty)
//   rd_data         head entry, zero while empty
//   full, empty     occupancy flags
module ets_sig_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  // A write into a full FIFO is accepted only when the head leaves the same cycle.
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ets_measure_ctrl.sv
// Sequencer between core issue/retire strobes and the ETS cycle counter.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   enable                        monitoring enable; low aborts a measurement in flight
//   core_issue/opcode/retire      core strobes
//   ctr_start/active/done         registered controls to the cycle counter
//   ctr_count/ctr_valid           result from the cycle counter
//   sig_valid/ready/opcode/cycles/timeout  record FIFO head to the signature checker
//   busy                          sequencer not idle
//   drop_count                    saturating count of ignored issues and discarded records
//   overflow                      sticky: a record was lost to a full FIFO
module ets_measure_ctrl
  import ets_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned OPC_W          = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             core_issue,
  input  logic [OPC_W-1:0] core_opcode,
  input  logic             core_retire,
  output logic             ctr_start,
  output logic             ctr_active,
  output logic             ctr_done,
  input  logic [31:0]      ctr_count,
  input  logic             ctr_valid,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [OPC_W-1:0] sig_opcode,
  output logic [31:0]      sig_cycles,
  output logic             sig_timeout,
  output logic             busy,
  output logic [15:0]      drop_count,
  output logic             overflow
);

  localparam int unsigned REC_W   = rec_width(OPC_W);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  ets_state_e       state, state_d;
  logic             start_d, active_d, done_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic [31:0]      wd_q, wd_d;
  logic             to_q, to_d;
  logic             capture;
  logic             issue_drop;
  logic             discard;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] rec_out;
  logic [16:0]      drop_sum;

  always_comb begin
    state_d    = state;
    start_d    = 1'b0;
    active_d   = 1'b0;
    done_d     = 1'b0;
    opc_d      = opc_q;
    wd_d       = wd_q;
    to_d       = to_q;
    capture    = 1'b0;
    issue_drop = 1'b0;
    case (state)
      IDLE: begin
        if (enable && core_issue) begin
          opc_d    = core_opcode;
          start_d  = 1'b1;
          active_d = 1'b1;
          wd_d     = '0;
          to_d     = 1'b0;
          state_d  = MEASURE;
        end
      end
      MEASURE: begin
        issue_drop = core_issue;
        active_d   = 1'b1;
        wd_d       = wd_q + 32'd1;
        // Abort beats retire beats watchdog expiry.
        if (!enable) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end else if (core_retire) begin
          active_d = 1'b0;
          done_d   = 1'b1;
          to_d     = 1'b0;
          state_d  = LATCH;
        end else if (wd_q == WD_LAST) begin
          active_d = 1'b0;
          done_d   = 1'b1;
          to_d     = 1'b1;
          state_d  = LATCH;
        end
      end
      LATCH: begin
        issue_drop = core_issue;
        if (ctr_valid) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop      = sig_valid & sig_ready;
  assign discard  = capture & fifo_full & ~pop;
  assign drop_sum = {1'b0, drop_count} + 17'(issue_drop) + 17'(discard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ctr_start  <= 1'b0;
      ctr_active <= 1'b0;
      ctr_done   <= 1'b0;
      opc_q      <= '0;
      wd_q       <= '0;
      to_q       <= 1'b0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_d;
      ctr_start  <= start_d;
      ctr_active <= active_d;
      ctr_done   <= done_d;
      opc_q      <= opc_d;
      wd_q       <= wd_d;
      to_q       <= to_d;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (discard) overflow <= 1'b1;
    end
  end

  assign rec_in = {opc_q, ctr_count, to_q};

  ets_sig_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (capture & ~discard),
    .wr_data (rec_in),
    .rd_en   (pop),
    .rd_data (rec_out),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign sig_valid   = ~fifo_empty;
  assign sig_opcode  = rec_out[REC_OPC_LSB +: OPC_W];
  assign sig_cycles  = rec_out[REC_CYC_LSB +: CYC_W];
  assign sig_timeout = rec_out[REC_TO_BIT];
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_ets_measure_ctrl.sv
// Randomized bench for ets_measure_ctrl against a transaction-level reference.
module tb_ets_measure_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;
  localparam int unsigned OW    = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          core_issue = 1'b0;
  logic [OW-1:0] core_opcode = '0;
  logic          core_retire = 1'b0;
  logic          ctr_start, ctr_active, ctr_done;
  logic [31:0]   ctr_count = '0;
  logic          ctr_valid = 1'b0;
  logic          sig_valid;
  logic          sig_ready = 1'b0;
  logic [OW-1:0] sig_opcode;
  logic [31:0]   sig_cycles;
  logic          sig_timeout;
  logic          busy;
  logic [15:0]   drop_count;
  logic          overflow;

  ets_measure_ctrl #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO),
    .OPC_W          (OW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .core_issue  (core_issue),
    .core_opcode (core_opcode),
    .core_retire (core_retire),
    .ctr_start   (ctr_start),
    .ctr_active  (ctr_active),
    .ctr_done    (ctr_done),
    .ctr_count   (ctr_count),
    .ctr_valid   (ctr_valid),
    .sig_valid   (sig_valid),
    .sig_ready   (sig_ready),
    .sig_opcode  (sig_opcode),
    .sig_cycles  (sig_cycles),
    .sig_timeout (sig_timeout),
    .busy        (busy),
    .drop_count  (drop_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0] op;
    logic [31:0]   cyc;
    logic          to;
  } rec_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  rec_t          q[$];
  rec_t          pend;
  int unsigned   exp_drop = 0;
  logic          exp_ovf = 1'b0;
  int unsigned   ready_pct = 0;
  logic          s_start = 1'b0, s_active = 1'b0, s_done = 1'b0;
  logic [31:0]   cnt = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: inputs set before the call are sampled by the edge; afterwards the
  // reference queue is advanced and the DUT outputs checked mid-cycle.
  task automatic tick(input logic e_busy, input logic e_start, input logic e_active, input logic e_done);
    @(negedge clk);
    if (sig_ready && q.size() != 0) q.delete(0);
    if (ctr_valid) begin
      if (q.size() < DEPTH) q.push_back(pend);
      else begin
        exp_drop++;
        exp_ovf = 1'b1;
      end
    end
    check_eq("busy", busy, e_busy);
    check_eq("ctr_start", ctr_start, e_start);
    check_eq("ctr_active", ctr_active, e_active);
    check_eq("ctr_done", ctr_done, e_done);
    check_eq("sig_valid", sig_valid, q.size() != 0);
    if (q.size() != 0) begin
      check_eq("sig_opcode", sig_opcode, q[0].op);
      check_eq("sig_cycles", sig_cycles, q[0].cyc);
      check_eq("sig_timeout", sig_timeout, q[0].to);
    end
    check_eq("drop_count", drop_count, exp_drop);
    check_eq("overflow", overflow, exp_ovf);
    // cycle_counter stand-in: counts active cycles, reports the cycle after done
    ctr_valid = s_done;
    if (s_start) cnt = 32'd1;
    else if (s_active) cnt = cnt + 32'd1;
    ctr_count = cnt;
    s_start  = ctr_start;
    s_active = ctr_active;
    s_done   = ctr_done;
    sig_ready = ($urandom_range(99) < ready_pct);
  endtask

  // extra_mode: 0 none, 1 stray issue at a random MEASURE cycle, 2 stray issue with the retire
  task automatic do_txn(input logic [OW-1:0] op, input int unsigned delay,
                        input int unsigned extra_mode, input bit want_abort);
    int unsigned last;
    int unsigned xj;
    int unsigned ab;
    bit          abort;
    last  = (delay >= TMO - 1) ? TMO - 1 : delay;
    xj    = (extra_mode == 2) ? delay : $urandom_range(last);
    abort = want_abort && (last > 0);
    ab    = (last > 0) ? $urandom_range(last - 1) : 0;
    pend.op  = op;
    pend.cyc = (delay >= TMO - 1) ? TMO : delay + 1;
    pend.to  = (delay >= TMO);
    enable = 1'b1;
    core_opcode = op;
    core_issue = 1'b1;
    core_retire = 1'b0;
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    core_issue = 1'b0;
    for (int unsigned j = 0; j <= last; j++) begin
      core_opcode = OW'($urandom);
      core_retire = !abort && (j == delay);
      core_issue  = (extra_mode != 0) && !abort && (j == xj);
      if (core_issue) exp_drop++;
      if (abort && j == ab) begin
        enable = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        break;
      end
      if (j == last) tick(1'b1, 1'b0, 1'b0, 1'b1);
      else           tick(1'b1, 1'b0, 1'b1, 1'b0);
    end
    if (!abort) begin
      for (int unsigned k = 0; k < 2; k++) begin
        core_retire = 1'($urandom_range(1));
        core_issue  = 1'($urandom_range(1));
        enable      = 1'($urandom_range(1));
        if (core_issue) exp_drop++;
        tick(k == 0, 1'b0, 1'b0, 1'b0);
      end
    end
    core_issue = 1'b0;
    core_retire = 1'b0;
    for (int unsigned g = $urandom_range(2); g > 0; g--) begin
      enable      = 1'b0;
      core_issue  = 1'($urandom_range(1));
      core_retire = 1'($urandom_range(1));
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
    enable = 1'b1;
    core_issue = 1'b0;
    core_retire = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_start"}, ctr_start, 1'b0);
    check_eq({tag, "_active"}, ctr_active, 1'b0);
    check_eq({tag, "_done"}, ctr_done, 1'b0);
    check_eq({tag, "_valid"}, sig_valid, 1'b0);
    check_eq({tag, "_opcode"}, sig_opcode, '0);
    check_eq({tag, "_cycles"}, sig_cycles, '0);
    check_eq({tag, "_timeout"}, sig_timeout, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_drop"}, drop_count, '0);
    check_eq({tag, "_ovf"}, overflow, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    enable = 1'b1;

    // basic retire, forced timeout, retire on the last watchdog cycle
    ready_pct = 0;
    do_txn(7'h33, 5, 0, 1'b0);
    do_txn(7'h11, 30, 0, 1'b0);
    do_txn(7'h22, TMO - 1, 0, 1'b0);
    // fill and overflow the FIFO with the consumer stalled
    do_txn(7'h44, 0, 0, 1'b0);
    do_txn(7'h55, 3, 0, 1'b0);
    do_txn(7'h66, 2, 0, 1'b0);
    ready_pct = 100;
    repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0);
    // stray issues, including one coincident with retire, then an abort
    do_txn(7'h12, 6, 1, 1'b0);
    do_txn(7'h13, 4, 2, 1'b0);
    do_txn(7'h14, 8, 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      ready_pct = $urandom_range(100);
      do_txn(OW'($urandom), $urandom_range(20), $urandom_range(2), ($urandom_range(5) == 0));
    end

    // asynchronous reset mid-measurement with records queued
    ready_pct = 0;
    sig_ready = 1'b0;
    do_txn(7'h21, 1, 0, 1'b0);
    do_txn(7'h23, 2, 1, 1'b0);
    core_opcode = 7'h25;
    core_issue = 1'b1;
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    core_issue = 1'b0;
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    q.delete();
    exp_drop = 0;
    exp_ovf = 1'b0;
    ctr_valid = 1'b0;
    cnt = '0;
    s_start = 1'b0;
    s_active = 1'b0;
    s_done = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    do_txn(7'h7F, 3, 0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL time_limit: simulation still running, required completion");
    $fatal(1, "time limit");
  end

endmodule
